// File: rtl/spi_reg_pkg.sv
// Shared encodings and helpers for the SPI command decoder / register bank.
package spi_reg_pkg;

  localparam int ADDR_W = 7;
  localparam int CMD_RD_BIT = 7;
  localparam logic [7:0] ERR_FILL = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  // Next burst address, wrapping from the last register back to 0.
  function automatic logic [ADDR_W-1:0] ptr_wrap_inc(input logic [ADDR_W-1:0] ptr,
                                                     input int num_regs);
    if (int'(ptr) >= num_regs - 1) begin
      return {ADDR_W{1'b0}};
    end else begin
      return ptr + 7'd1;
    end
  endfunction

endpackage

// File: rtl/spi_reg_array.sv
// RW register storage with a combined RW/RO asynchronous read port.
// Addresses below RO_BASE hit storage, RO_BASE..NUM_REGS-1 hit ro_in, anything else reads 0.
module spi_reg_array
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int RO_BASE  = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [7:0]                        wr_data,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic [7:0]                        rd_data,
  input  logic [8*(NUM_REGS-RO_BASE)-1:0]   ro_in,
  output logic [8*RO_BASE-1:0]              rw_out
);

  logic [8*RO_BASE-1:0] mem_r;

  // RW storage, cleared by reset, one byte written per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r <= {(8*RO_BASE){1'b0}};
    end else begin
      for (int k = 0; k < RO_BASE; k++) begin
        if (wr_en && (wr_addr == ADDR_W'(k))) begin
          mem_r[8*k +: 8] <= wr_data;
        end
      end
    end
  end

  // AND-OR read mux over RW storage and the live RO sources.
  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < RO_BASE; k++) begin
      rd_data = rd_data | ({8{rd_addr == ADDR_W'(k)}} & mem_r[8*k +: 8]);
    end
    for (int j = 0; j < NUM_REGS - RO_BASE; j++) begin
      rd_data = rd_data | ({8{rd_addr == ADDR_W'(RO_BASE + j)}} & ro_in[8*j +: 8]);
    end
  end

  assign rw_out = mem_r;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI byte-level command decoder and register file (top).
// Define SPI_REG_AUTOINC_EN for burst auto-increment of the address pointer.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int RO_BASE  = 24
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cs,
  input  logic [7:0]                        rx_byte,
  input  logic                              rx_valid,
  output logic [7:0]                        tx_byte,
  output logic                              tx_load,
  output logic [8*RO_BASE-1:0]              rw_out,
  input  logic [8*(NUM_REGS-RO_BASE)-1:0]   ro_in,
  output logic                              wr_strobe,
  output logic [ADDR_W-1:0]                 wr_addr,
  input  logic                              clr_err,
  output logic                              err
);

`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_ptr_r;
  logic [ADDR_W-1:0]   next_ptr_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [7:0]          rd_data_s;
  logic                byte_s;
  logic                cmd_bad_s;
  logic                wr_ok_s;
  logic                wr_en_s;
  logic                err_set_s;

  // Pointer advance, read address selection and byte qualification.
  always_comb begin
    if (AUTOINC) begin
      next_ptr_s = ptr_wrap_inc(addr_ptr_r, NUM_REGS);
    end else begin
      next_ptr_s = addr_ptr_r;
    end
    // The command byte's own address feeds the mux so the first read byte is ready at N+1.
    if (state_r == ST_CMD) begin
      rd_addr_s = rx_byte[ADDR_W-1:0];
    end else begin
      rd_addr_s = next_ptr_s;
    end
    byte_s    = rx_valid && !cs;
    cmd_bad_s = int'(rx_byte[ADDR_W-1:0]) >= NUM_REGS;
    wr_ok_s   = int'(addr_ptr_r) < RO_BASE;
    wr_en_s   = byte_s && (state_r == ST_WRITE) && wr_ok_s;
    err_set_s = byte_s && (state_r == ST_CMD) && cmd_bad_s;
  end

  spi_reg_array #(
    .NUM_REGS (NUM_REGS),
    .RO_BASE  (RO_BASE)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (addr_ptr_r),
    .wr_data (rx_byte),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s),
    .ro_in   (ro_in),
    .rw_out  (rw_out)
  );

  // Transaction FSM with registered tx, strobe and sticky error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      addr_ptr_r <= {ADDR_W{1'b0}};
      tx_byte    <= 8'h00;
      tx_load    <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= {ADDR_W{1'b0}};
      err        <= 1'b0;
    end else begin
      tx_load   <= 1'b0;
      wr_strobe <= 1'b0;
      err       <= err_set_s | (err & ~clr_err);
      if (cs) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_CMD;
          ST_CMD: begin
            if (rx_valid) begin
              addr_ptr_r <= rx_byte[ADDR_W-1:0];
              if (cmd_bad_s) begin
                state_r <= ST_DISCARD;
                tx_byte <= ERR_FILL;
                tx_load <= 1'b1;
              end else if (rx_byte[CMD_RD_BIT]) begin
                state_r <= ST_READ;
                tx_byte <= rd_data_s;
                tx_load <= 1'b1;
              end else begin
                state_r <= ST_WRITE;
                tx_byte <= 8'h00;
              end
            end
          end
          ST_WRITE: begin
            if (rx_valid) begin
              addr_ptr_r <= next_ptr_s;
              if (wr_ok_s) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr_ptr_r;
              end
            end
          end
          ST_READ: begin
            if (rx_valid) begin
              addr_ptr_r <= next_ptr_s;
              tx_byte    <= rd_data_s;
              tx_load    <= 1'b1;
            end
          end
          ST_DISCARD: state_r <= ST_DISCARD;
          default:    state_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
